mem_access_unit: RTL

CPU-side initiator for data-memory traffic. It accepts one load/store per transaction from the MEM stage and checks alignment. It converts the access into a word-aligned bus transaction with byte enables, waits for the memory's acknowledge, then returns sign- or zero-extended load data. The MEM stage is held via `busy` while a transaction is outstanding. It sits between the pipeline's MEM stage and the (possibly multi-cycle) data memory.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/load_extend.sv | 33 +++
 rtl/mem_access_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: op codes, FSM states,
// byte-enable patterns and alignment helpers.
package mem_pkg;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_W    = 3'd1;
    localparam logic [2:0] OP_HS   = 3'd2;
    localparam logic [2:0] OP_BS   = 3'd3;
    localparam logic [2:0] OP_HU   = 3'd4;
    localparam logic [2:0] OP_BU   = 3'd5;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } state_t;

    // Ops 6/7 behave like OP_NONE.
    function automatic logic op_is_access(input logic [2:0] op);
        return (op >= OP_W) && (op <= OP_BU);
    endfunction

    function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            OP_W:         return lo == 2'b00;
            OP_HS, OP_HU: return lo[0] == 1'b0;
            default:      return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed half/byte lane of a read word and sign- or zero-extends it.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    // Lane selection and extension
    always_comb begin
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        case (op)
            OP_W:    data = rdata;
            OP_HS:   data = {{16{half_v[15]}}, half_v};
            OP_HU:   data = {16'h0000, half_v};
            OP_BS:   data = {{24{byte_v[7]}}, byte_v};
            OP_BU:   data = {24'h000000, byte_v};
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: checks alignment, issues one word-aligned bus request
// with byte enables, waits for ack and returns extended load data.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              addr_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack
);

    state_t            state_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              addr_err_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [3:0]        bus_be_q;
    logic [31:0]       bus_wdata_q;
    logic [2:0]        op_q;
    logic [1:0]        addr_lo_q;

    logic              accept;
    logic              misalign;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [31:0]       ext_data;

    // Request decode: acceptance, alignment error, lane enables and replication
    always_comb begin
        accept   = 1'b0;
        misalign = 1'b0;
        if (state_q == StIdle && req_valid && op_is_access(req_op)) begin
            accept   = is_aligned(req_op, req_addr[1:0]);
            misalign = !is_aligned(req_op, req_addr[1:0]);
        end
        case (req_op)
            OP_W: begin
                be_d    = BE_WORD;
                wdata_d = req_wdata;
            end
            OP_HS, OP_HU: begin
                be_d    = req_addr[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_d = {2{req_wdata[15:0]}};
            end
            OP_BS, OP_BU: begin
                be_d    = BE_BYTE0 << req_addr[1:0];
                wdata_d = {4{req_wdata[7:0]}};
            end
            default: begin
                be_d    = BE_NONE;
                wdata_d = 32'h0000_0000;
            end
        endcase
    end

    load_extend u_load_extend (
        .rdata   (bus_rdata),
        .op      (op_q),
        .addr_lo (addr_lo_q),
        .data    (ext_data)
    );

    // Transaction FSM with registered outputs; bus fields are cleared on ack
    // so they read 0 whenever no request is outstanding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            addr_err_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= BE_NONE;
            bus_wdata_q <= 32'h0000_0000;
            op_q        <= OP_NONE;
            addr_lo_q   <= 2'b00;
        end else begin
            addr_err_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q     <= StReq;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= req_we;
                        bus_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                        bus_be_q    <= be_d;
                        bus_wdata_q <= wdata_d;
                        op_q        <= req_op;
                        addr_lo_q   <= req_addr[1:0];
                    end else if (misalign) begin
                        addr_err_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (bus_ack) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= bus_we_q ? 32'h0000_0000 : ext_data;
                        bus_req_q   <= 1'b0;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= '0;
                        bus_be_q    <= BE_NONE;
                        bus_wdata_q <= 32'h0000_0000;
                    end
                end
                StResp: begin
                    state_q     <= StIdle;
                    rsp_rdata_q <= 32'h0000_0000;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = (state_q != StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign addr_err  = addr_err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule
